// File: rtl/bus_window_ctrl_if.sv
// CPU-side request/response and target-side bus signals of bus_window_ctrl.
// The slave modport is the controller; the master modport is the CPU/target environment.
interface bus_window_ctrl_if #(
  parameter int P_width = 16,
  parameter int P_data  = 8
);
  logic               I_req;
  logic [P_width-1:0] I_addr;
  logic               I_write;
  logic [P_data-1:0]  I_wdata;
  logic               O_busy;
  logic               O_ack;
  logic [P_data-1:0]  O_rdata;
  logic               O_miss;
  logic [1:0]         O_cs;
  logic [P_width-1:0] O_addr;
  logic               O_write;
  logic [P_data-1:0]  O_wdata;
  logic [P_data-1:0]  I_rdata0;
  logic [P_data-1:0]  I_rdata1;

  modport slave (
    input  I_req, I_addr, I_write, I_wdata, I_rdata0, I_rdata1,
    output O_busy, O_ack, O_rdata, O_miss, O_cs, O_addr, O_write, O_wdata
  );

  modport master (
    output I_req, I_addr, I_write, I_wdata, I_rdata0, I_rdata1,
    input  O_busy, O_ack, O_rdata, O_miss, O_cs, O_addr, O_write, O_wdata
  );
endinterface

// File: rtl/bus_window_ctrl.sv
// Two-window bus access controller: decodes a CPU request against half-open
// address windows, drives a registered chip-select, inserts wait states, acks.
module bus_window_ctrl #(
  parameter int                 P_width = 16,
  parameter int                 P_data  = 8,
  parameter logic [P_width-1:0] P_lo0   = 16'h0000,
  parameter logic [P_width-1:0] P_hi0   = 16'h0800,
  parameter logic [P_width-1:0] P_lo1   = 16'h8000,
  parameter logic [P_width-1:0] P_hi1   = 16'hFFFF,
  parameter int                 P_wait0 = 0,
  parameter int                 P_wait1 = 2,
  parameter logic [P_data-1:0]  P_open  = 8'hFF
) (
  input  logic             I_clock,
  input  logic             I_reset_n,
  bus_window_ctrl_if.slave bus
);

  localparam logic [3:0] LP_WAIT0 = 4'(P_wait0);
  localparam logic [3:0] LP_WAIT1 = 4'(P_wait1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic               w_accept;
  logic               w_finish;
  logic               w_busy;

  logic [P_width-1:0] w_lo [2];
  logic [P_width-1:0] w_hi [2];
  logic [1:0]         w_hit;
  logic [1:0]         w_cs_next;
  logic [3:0]         w_wait;

  logic [3:0]         r_count;
  logic               r_miss_flag;
  logic               r_ack;
  logic [P_data-1:0]  r_rdata;
  logic               r_miss;
  logic [1:0]         r_cs;
  logic [P_width-1:0] r_addr;
  logic               r_write;
  logic [P_data-1:0]  r_wdata;

  // Bounds go through nets so the window compare stays a plain unsigned test
  // even when a bound is zero; lo >= hi naturally yields no hit.
  assign w_lo[0] = P_lo0;
  assign w_hi[0] = P_hi0;
  assign w_lo[1] = P_lo1;
  assign w_hi[1] = P_hi1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      assign w_hit[gi] = (bus.I_addr >= w_lo[gi]) && (bus.I_addr < w_hi[gi]);
    end
  endgenerate

  // Window 0 has priority when the windows overlap.
  assign w_cs_next = {w_hit[1] & ~w_hit[0], w_hit[0]};
  assign w_wait    = w_hit[0] ? LP_WAIT0 : (w_hit[1] ? LP_WAIT1 : 4'd0);

  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.I_req) w_state_next = S_ACCESS;
      S_ACCESS: if (r_count == 4'd0) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_finish = 1'b0;
    w_busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy   = 1'b0;
        w_accept = bus.I_req;
      end
      S_ACCESS: w_finish = (r_count == 4'd0);
      default:  ;
    endcase
  end

  always_ff @(posedge I_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_count     <= 4'd0;
      r_miss_flag <= 1'b0;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_miss      <= 1'b0;
      r_cs        <= 2'b00;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_ack <= w_finish;
      if (w_accept) begin
        r_addr      <= bus.I_addr;
        r_write     <= bus.I_write;
        r_wdata     <= bus.I_wdata;
        r_cs        <= w_cs_next;
        r_count     <= w_wait;
        r_miss_flag <= ~(|w_hit);
      end else if (w_finish) begin
        if (!r_write) begin
          if (r_miss_flag)  r_rdata <= P_open;
          else if (r_cs[0]) r_rdata <= bus.I_rdata0;
          else              r_rdata <= bus.I_rdata1;
        end
        r_miss <= r_miss_flag;
        r_cs   <= 2'b00;
      end else if (r_state == S_ACCESS) begin
        r_count <= r_count - 4'd1;
      end
    end
  end

  assign bus.O_busy  = w_busy;
  assign bus.O_ack   = r_ack;
  assign bus.O_rdata = r_rdata;
  assign bus.O_miss  = r_miss;
  assign bus.O_cs    = r_cs;
  assign bus.O_addr  = r_addr;
  assign bus.O_write = r_write;
  assign bus.O_wdata = r_wdata;

endmodule

// File: doc/bus_window_ctrl.md
Name: bus_window_ctrl

Overview:
- Sequential bus-access controller downstream of the address range comparator.
- Accepts a single-cycle CPU bus request and decodes the address against two half-open windows [lower, upper), using the same inclusive-lower / exclusive-upper rule as the comparator.
- Drives a registered chip-select to the matching target, inserts per-window wait states, returns read data and a one-cycle acknowledge.

Parameters:
P_width, 16, address width
P_data, 8, data width
P_lo0, 16'h0000, window 0 lower bound (inclusive)
P_hi0, 16'h0800, window 0 upper bound (exclusive)
P_lo1, 16'h8000, window 1 lower bound (inclusive)
P_hi1, 16'hFFFF, window 1 upper bound (exclusive)
P_wait0, 0, wait states for window 0 (0..15)
P_wait1, 2, wait states for window 1 (0..15)
P_open, 8'hFF, read data returned on a miss

Ports:
I_clock  in  1  system clock, rising edge
I_reset_n  in  1  asynchronous active-low reset
I_req  in  1  request strobe, sampled only in IDLE
I_addr  in  P_width  request address
I_write  in  1  1 = write, 0 = read
I_wdata  in  P_data  write data
O_busy  out  1  high in any state other than IDLE
O_ack  out  1  one-cycle completion pulse
O_rdata  out  P_data  read result, valid with O_ack, held until the next ack
O_miss  out  1  valid with O_ack: address hit no window
O_cs  out  2  one-hot target select, registered
O_addr  out  P_width  latched address to targets
O_write  out  1  latched direction to targets
O_wdata  out  P_data  latched write data to targets
I_rdata0  in  P_data  window 0 target read data
I_rdata1  in  P_data  window 1 target read data

Behaviour:
- One clock: I_clock.
- Reset is asynchronous and active-low on I_reset_n. While I_reset_n = 0: state IDLE, every output 0 (O_busy, O_ack, O_rdata, O_miss, O_cs, O_addr, O_write, O_wdata), wait counter 0.
- Hit rule: hitN = (I_addr >= P_loN) && (I_addr < P_hiN), unsigned P_width compare.
  - A window with lo >= hi never hits.
  - Address 16'hFFFF can never hit window 1 with the defaults.
- Priority: when both windows hit, window 0 wins.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE (edge N, I_req = 1):
  - Latch I_addr, I_write, I_wdata onto O_addr, O_write, O_wdata.
  - On a hit: O_cs = one-hot of the selected window; counter = P_waitN.
  - On a miss: O_cs = 0; counter = 0; internal miss flag set.
  - Next state ACCESS, so O_busy = 1 from cycle N+1.
- IDLE with I_req = 0: no change.
- ACCESS:
  - counter != 0: decrement, stay in ACCESS.
  - counter == 0:
    - Read hit: capture the selected I_rdataN into O_rdata.
    - Read miss: O_rdata = P_open.
    - Write: O_rdata unchanged.
    - O_miss = flag; O_cs = 0; O_ack = 1; next state DONE.
- DONE: O_ack = 1 for this cycle only; O_busy = 1; next state IDLE.
- Latency: strobe sampled at edge N. O_cs is high for cycles N+1 .. N+1+W, O_ack is high in cycle N+2+W, and the next request is accepted at edge N+3+W.
- Targets see stable O_addr, O_write, O_wdata for the whole time O_cs is high. O_addr, O_write and O_wdata hold after completion.
- I_req while O_busy = 1 is ignored and not queued; there is no error flag.
- Reset asserted mid-ACCESS or mid-DONE: the transaction is abandoned, no ack is issued, all outputs clear immediately.
- O_miss is updated only at completion and holds until the next completion.

Test Plan:
- Read at 16'h0010, P_wait0 = 0, I_rdata0 = 8'h5A, req at edge 0 -> O_cs = 2'b01 in cycle 1 only; O_ack in cycle 2; O_rdata = 8'h5A; O_miss = 0.
- Write at 16'h8000 with 8'hC3, P_wait1 = 2 -> O_cs = 2'b10 for cycles 1-3; O_write = 1; O_wdata = 8'hC3; O_ack in cycle 4; O_rdata unchanged.
- Boundaries: read 16'h0800 -> miss, O_cs stays 0, O_ack in cycle 2, O_rdata = 8'hFF, O_miss = 1. Read 16'h07FF -> window 0 hit. Read 16'hFFFF -> miss.
- Overlap: P_lo1 = 16'h0400 and read 16'h0500 -> window 0 selected (O_cs = 2'b01); uses P_wait0 latency.
- Second strobe in cycle 1 of a window 1 access -> ignored. Exactly one O_ack (cycle 4). O_addr keeps the first address. A new request at edge 5 is accepted.
- I_reset_n low in cycle 2 of a window 1 access -> O_cs, O_busy, O_rdata drop to 0 asynchronously. No O_ack follows. A request after reset release completes normally.
